// File: rtl/fjs_pkg.sv
// Shared types for the fork/join sequencer: join modes, FSM states and channel bound.
package fjs_pkg;

   localparam int unsigned NUM_CH_MAX = 16;

   typedef enum logic [1:0] {
      JOIN_ALL  = 2'b00,
      JOIN_ANY  = 2'b01,
      JOIN_NONE = 2'b10,
      RESERVED  = 2'b11
   } join_mode_e;

   typedef enum logic [1:0] {
      IDLE,
      WAIT_JOIN,
      RUN_POST,
      DRAIN
   } state_e;

endpackage

// File: rtl/fjs_timer.sv
// Loadable countdown timer: busy from the load edge, one-cycle done pulse in its last busy cycle.
module fjs_timer #(
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_load,
   input  logic [CNT_W-1:0] i_delay,
   output logic             o_busy,
   output logic             o_done
);

   logic [CNT_W-1:0] r_cnt;
   logic             r_busy;
   logic             r_done;
   logic [CNT_W-1:0] w_eff;

   // A zero duration behaves as one cycle.
   always_comb begin
      w_eff = i_delay;
      if (i_delay == '0) w_eff = CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt  <= '0;
         r_busy <= 1'b0;
         r_done <= 1'b0;
      end else if (i_load) begin
         r_cnt  <= w_eff;
         r_busy <= 1'b1;
         r_done <= (w_eff == CNT_W'(1));
      end else if (r_busy) begin
         r_cnt  <= r_cnt - CNT_W'(1);
         r_busy <= (r_cnt != CNT_W'(1));
         r_done <= (r_cnt == CNT_W'(2));
      end else begin
         r_done <= 1'b0;
      end
   end

   assign o_busy = r_busy;
   assign o_done = r_done;

endmodule

// File: rtl/fork_join_sequencer.sv
// Launches NUM_CH parallel timers, then a post timer on the selected join event, and reports completion.
module fork_join_sequencer
   import fjs_pkg::*;
#(
   parameter int unsigned NUM_CH = 2,
   parameter int unsigned CNT_W  = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic [1:0]              mode,
   input  logic [NUM_CH*CNT_W-1:0] ch_delay,
   input  logic [CNT_W-1:0]        post_delay,
   output logic [NUM_CH-1:0]       ch_busy,
   output logic [NUM_CH-1:0]       ch_done,
   output logic                    post_busy,
   output logic                    post_done,
   output logic                    busy,
   output logic                    all_done
);

   if (NUM_CH < 1 || NUM_CH > NUM_CH_MAX) begin : g_bad_num_ch
      $error("fork_join_sequencer: NUM_CH out of range");
   end

   state_e           r_state;
   state_e           w_next;
   join_mode_e       r_mode;
   logic [CNT_W-1:0] r_post_delay;

   logic [NUM_CH-1:0] w_ch_busy;
   logic [NUM_CH-1:0] w_ch_done;
   logic [NUM_CH-1:0] w_remaining;
   logic              w_ch_load;
   logic              w_post_load;
   logic              w_post_busy;
   logic              w_post_done;
   logic              w_join_hit;
   logic              w_all_done;
   logic [CNT_W-1:0]  w_post_dly;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= IDLE;
         r_mode       <= JOIN_ALL;
         r_post_delay <= '0;
      end else begin
         r_state <= w_next;
         if (r_state == IDLE && start) begin
            r_mode       <= join_mode_e'(mode);
            r_post_delay <= post_delay;
         end
      end
   end

   // Channels still running after the current edge.
   assign w_remaining = w_ch_busy & ~w_ch_done;

   // Join-any fires on the first completion; join-all (and reserved) when nothing remains.
   always_comb begin
      w_join_hit = (w_remaining == '0);
      if (r_mode == JOIN_ANY) w_join_hit = |w_ch_done;
   end

   // Join-none loads the post timer at launch, before the mode register is written.
   assign w_post_dly = (r_state == IDLE) ? post_delay : r_post_delay;

   always_comb begin
      w_next      = r_state;
      w_ch_load   = 1'b0;
      w_post_load = 1'b0;
      w_all_done  = 1'b0;
      case (r_state)
         IDLE: begin
            if (start) begin
               w_ch_load = 1'b1;
               if (join_mode_e'(mode) == JOIN_NONE) begin
                  w_post_load = 1'b1;
                  w_next      = RUN_POST;
               end else begin
                  w_next = WAIT_JOIN;
               end
            end
         end
         WAIT_JOIN: begin
            if (w_join_hit) begin
               w_post_load = 1'b1;
               w_next      = RUN_POST;
            end
         end
         RUN_POST: begin
            if (w_post_done) begin
               if (w_remaining != '0) begin
                  w_next = DRAIN;
               end else begin
                  w_next     = IDLE;
                  w_all_done = 1'b1;
               end
            end
         end
         DRAIN: begin
            if (w_remaining == '0) begin
               w_next     = IDLE;
               w_all_done = 1'b1;
            end
         end
         default: w_next = IDLE;
      endcase
   end

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      fjs_timer #(.CNT_W(CNT_W)) u_ch_timer (
         .clk     (clk),
         .rst     (rst),
         .i_load  (w_ch_load),
         .i_delay (ch_delay[i*CNT_W +: CNT_W]),
         .o_busy  (w_ch_busy[i]),
         .o_done  (w_ch_done[i])
      );
   end

   fjs_timer #(.CNT_W(CNT_W)) u_post_timer (
      .clk     (clk),
      .rst     (rst),
      .i_load  (w_post_load),
      .i_delay (w_post_dly),
      .o_busy  (w_post_busy),
      .o_done  (w_post_done)
   );

   assign ch_busy   = w_ch_busy;
   assign ch_done   = w_ch_done;
   assign post_busy = w_post_busy;
   assign post_done = w_post_done;
   assign busy      = (r_state != IDLE);
   assign all_done  = w_all_done;

endmodule

// File: tb/tb_fork_join_sequencer.sv
// Scoreboard bench: directed launches push expected done events, a monitor pops and compares them.
module tb_fork_join_sequencer;

   localparam int unsigned NUM_CH = 2;
   localparam int unsigned CNT_W  = 8;

   logic                    clk = 1'b0;
   logic                    rst;
   logic                    start;
   logic [1:0]              mode;
   logic [NUM_CH*CNT_W-1:0] ch_delay;
   logic [CNT_W-1:0]        post_delay;
   logic [NUM_CH-1:0]       ch_busy;
   logic [NUM_CH-1:0]       ch_done;
   logic                    post_busy;
   logic                    post_done;
   logic                    busy;
   logic                    all_done;

   typedef struct {
      int unsigned at;
      logic [1:0]  ch;
      logic        post;
      logic        all;
   } ev_t;

   ev_t         q[$];
   int unsigned cyc = 0;
   int          n_tests = 0;
   int          n_fail = 0;
   int unsigned e0;

   fork_join_sequencer #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .mode       (mode),
      .ch_delay   (ch_delay),
      .post_delay (post_delay),
      .ch_busy    (ch_busy),
      .ch_done    (ch_done),
      .post_busy  (post_busy),
      .post_done  (post_done),
      .busy       (busy),
      .all_done   (all_done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: every done pulse must match the head of the queue; tagged with the edge ending its cycle.
   initial begin
      ev_t e;
      forever begin
         @(negedge clk);
         if (!rst && (ch_done != '0 || post_done || all_done)) begin
            n_tests++;
            if (q.size() == 0) begin
               n_fail++;
               $display("FAIL unexpected_event edge=%0d got ch=%b post=%b all=%b required none",
                        cyc + 1, ch_done, post_done, all_done);
            end else begin
               e = q.pop_front();
               if (e.at != cyc + 1 || e.ch != ch_done || e.post != post_done || e.all != all_done) begin
                  n_fail++;
                  $display("FAIL event got edge=%0d ch=%b post=%b all=%b required edge=%0d ch=%b post=%b all=%b",
                           cyc + 1, ch_done, post_done, all_done, e.at, e.ch, e.post, e.all);
               end
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h required=%0h", name, got, exp);
      end
   endtask

   // Offsets are relative to the launch edge E0.
   task automatic expect_ev(input int unsigned off, input logic [1:0] ch, input logic p, input logic a);
      ev_t e;
      e.at = e0 + off; e.ch = ch; e.post = p; e.all = a;
      q.push_back(e);
   endtask

   // Called at a negedge: the next rising edge is E0.
   task automatic arm();
      e0 = cyc + 1;
   endtask

   task automatic launch(input logic [1:0] m, input logic [7:0] d0, input logic [7:0] d1,
                         input logic [7:0] pd);
      mode = m; ch_delay = {d1, d0}; post_delay = pd; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_to(input int unsigned off);
      while (cyc < e0 + off) @(negedge clk);
   endtask

   task automatic finish_op(input string name);
      int budget = 300;
      while (busy && budget > 0) begin
         @(negedge clk);
         budget--;
      end
      check({name, "_idle"}, 32'(busy), 32'd0);
      repeat (3) @(negedge clk);
      check({name, "_queue_empty"}, 32'(q.size()), 32'd0);
      q.delete();
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; mode = 2'b00; ch_delay = '0; post_delay = '0;
      repeat (3) @(negedge clk);
      check("reset_outputs", 32'({ch_busy, ch_done, post_busy, post_done, busy, all_done}), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // Join-any {20,10} post 30, with a stray start mid-run.
      arm();
      expect_ev(10, 2'b10, 1'b0, 1'b0);
      expect_ev(20, 2'b01, 1'b0, 1'b0);
      expect_ev(40, 2'b00, 1'b1, 1'b1);
      launch(2'b01, 8'd20, 8'd10, 8'd30);
      check("any_ch_busy_e0", 32'(ch_busy), 32'h3);
      wait_to(3);
      mode = 2'b10; ch_delay = {8'd1, 8'd1}; post_delay = 8'd1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_to(9);
      check("any_post_idle_before_join", 32'(post_busy), 32'd0);
      wait_to(10);
      check("any_post_busy_at_join", 32'(post_busy), 32'd1);
      wait_to(39);
      check("any_busy_last_cycle", 32'(busy), 32'd1);
      finish_op("join_any");

      // Join-all.
      arm();
      expect_ev(10, 2'b10, 1'b0, 1'b0);
      expect_ev(20, 2'b01, 1'b0, 1'b0);
      expect_ev(50, 2'b00, 1'b1, 1'b1);
      launch(2'b00, 8'd20, 8'd10, 8'd30);
      wait_to(19);
      check("all_post_idle_before_join", 32'(post_busy), 32'd0);
      finish_op("join_all");

      // Join-none.
      arm();
      expect_ev(10, 2'b10, 1'b0, 1'b0);
      expect_ev(20, 2'b01, 1'b0, 1'b0);
      expect_ev(30, 2'b00, 1'b1, 1'b1);
      launch(2'b10, 8'd20, 8'd10, 8'd30);
      check("none_post_busy_e0", 32'(post_busy), 32'd1);
      finish_op("join_none");

      // Join-any tie: one post launch only.
      arm();
      expect_ev(5, 2'b11, 1'b0, 1'b0);
      expect_ev(8, 2'b00, 1'b1, 1'b1);
      launch(2'b01, 8'd5, 8'd5, 8'd3);
      finish_op("tie");

      // Drain: post completes while channel 0 still runs.
      arm();
      expect_ev(10, 2'b10, 1'b0, 1'b0);
      expect_ev(15, 2'b00, 1'b1, 1'b0);
      expect_ev(40, 2'b01, 1'b0, 1'b1);
      launch(2'b01, 8'd40, 8'd10, 8'd5);
      wait_to(20);
      check("drain_status", 32'({busy, post_busy, ch_busy}), 32'b1_0_01);
      finish_op("drain");

      // Reserved mode acts as join-all.
      arm();
      expect_ev(2, 2'b10, 1'b0, 1'b0);
      expect_ev(4, 2'b01, 1'b0, 1'b0);
      expect_ev(5, 2'b00, 1'b1, 1'b1);
      launch(2'b11, 8'd4, 8'd2, 8'd1);
      finish_op("reserved");

      // Zero delays behave as one cycle.
      arm();
      expect_ev(1, 2'b01, 1'b0, 1'b0);
      expect_ev(2, 2'b10, 1'b1, 1'b1);
      launch(2'b01, 8'd0, 8'd2, 8'd0);
      finish_op("zero_delay");

      // Reset at cycle 12 aborts silently.
      arm();
      expect_ev(10, 2'b10, 1'b0, 1'b0);
      launch(2'b00, 8'd20, 8'd10, 8'd30);
      wait_to(11);
      rst = 1'b1;
      @(negedge clk);
      check("abort_outputs", 32'({ch_busy, ch_done, post_busy, post_done, busy, all_done}), 32'd0);
      rst = 1'b0;
      wait_to(60);
      check("abort_idle", 32'(busy), 32'd0);
      check("abort_queue_empty", 32'(q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
